// File: rtl/stereo_chorus.sv
// Stereo chorus: circular delay buffer read at a triangle-LFO-swept delay, 50/50 dry/wet mix.
// Latency 3 cycles from accepted strobe to sample_valid_o; strobes arriving mid-pipeline are dropped (no backpressure).
module stereo_chorus #(
   parameter int WIDTH    = 16,
   parameter int ADDR_W   = 10,
   parameter int BASE_DLY = 256
) (
   input  logic                    sclk_i,
   input  logic                    rst_n_i,
   input  logic                    sample_valid_i,
   input  logic signed [WIDTH-1:0] leftChan_i,
   input  logic signed [WIDTH-1:0] rightChan_i,
   input  logic [3:0]              depthSetting_i,
   input  logic [3:0]              freqSetting_i,
   output logic                    sample_valid_o,
   output logic signed [WIDTH-1:0] leftChan_o,
   output logic signed [WIDTH-1:0] rightChan_o
);

   localparam logic [9:0] PRIME_CNT = 10'd512;

   typedef struct packed {
      logic signed [WIDTH-1:0] left;
      logic signed [WIDTH-1:0] right;
   } pair_t;

   typedef enum logic [1:0] {IDLE, RD, MIX} state_t;

   state_t              state_q, state_d;
   pair_t               mem [2**ADDR_W];
   pair_t               rd_q, dry_q, wet;
   logic [ADDR_W-1:0]   wr_ptr, rd_addr, dly;
   logic [15:0]         ph;
   logic [7:0]          tri_v;
   logic [11:0]         prod;
   logic [9:0]          prime_cnt;
   logic                primed_q;
   logic                accept, rd_en, mix;
   logic signed [WIDTH-1:0] mix_l, mix_r;

   // Triangle LFO derived from the pre-update phase of the accepted sample
   always_comb begin
      tri_v = ph[15] ? ~ph[14:7] : ph[14:7];
      prod  = tri_v * depthSetting_i;
      dly   = ADDR_W'(BASE_DLY) + ADDR_W'(prod[11:4]);
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      rd_en   = 1'b0;
      mix     = 1'b0;
      case (state_q)
         IDLE: if (sample_valid_i) begin
            accept  = 1'b1;
            state_d = RD;
         end
         RD: begin
            rd_en   = 1'b1;
            state_d = MIX;
         end
         MIX: begin
            mix     = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Buffer contents survive reset; only the pointers are cleared
   always_ff @(posedge sclk_i) begin
      if (accept && rst_n_i) mem[wr_ptr] <= '{left: leftChan_i, right: rightChan_i};
      if (rd_en) rd_q <= mem[rd_addr];
   end

   always_comb begin
      wet   = primed_q ? rd_q : '0;
      mix_l = (dry_q.left  >>> 1) + (wet.left  >>> 1);
      mix_r = (dry_q.right >>> 1) + (wet.right >>> 1);
   end

   always_ff @(posedge sclk_i) begin
      if (!rst_n_i) begin
         state_q        <= IDLE;
         wr_ptr         <= '0;
         ph             <= '0;
         prime_cnt      <= '0;
         sample_valid_o <= 1'b0;
         leftChan_o     <= '0;
         rightChan_o    <= '0;
      end else begin
         state_q        <= state_d;
         sample_valid_o <= mix;
         if (accept) begin
            dry_q    <= '{left: leftChan_i, right: rightChan_i};
            rd_addr  <= wr_ptr - dly;
            wr_ptr   <= wr_ptr + 1'b1;
            ph       <= ph + {12'd0, freqSetting_i};
            primed_q <= (prime_cnt == PRIME_CNT);
            if (prime_cnt != PRIME_CNT) prime_cnt <= prime_cnt + 1'b1;
         end
         if (mix) begin
            leftChan_o  <= mix_l;
            rightChan_o <= mix_r;
         end
      end
   end

endmodule

// File: tb/tb_stereo_chorus.sv
// Bench for stereo_chorus: directed and randomized strobes checked against a sample-history model.
module tb_stereo_chorus;

   localparam int BASE = 256;

   logic        sclk_i = 1'b0;
   logic        rst_n_i;
   logic        sample_valid_i;
   logic [15:0] leftChan_i, rightChan_i;
   logic [3:0]  depthSetting_i, freqSetting_i;
   logic        sample_valid_o;
   logic [15:0] leftChan_o, rightChan_o;

   always #5 sclk_i = ~sclk_i;

   stereo_chorus #(.WIDTH(16), .ADDR_W(10), .BASE_DLY(BASE)) dut (
      .sclk_i        (sclk_i),
      .rst_n_i       (rst_n_i),
      .sample_valid_i(sample_valid_i),
      .leftChan_i    (leftChan_i),
      .rightChan_i   (rightChan_i),
      .depthSetting_i(depthSetting_i),
      .freqSetting_i (freqSetting_i),
      .sample_valid_o(sample_valid_o),
      .leftChan_o    (leftChan_o),
      .rightChan_o   (rightChan_o)
   );

   typedef struct {
      int cyc;
      int l;
      int r;
   } exp_t;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   ph = 0;
   int   hist_l[$];
   int   hist_r[$];
   exp_t expq[$];
   bit   prev_vld = 1'b0;

   always @(posedge sclk_i) cyc = cyc + 1;

   task automatic chk(input string nm, input int act, input int exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   task automatic model_reset();
      ph = 0;
      hist_l.delete();
      hist_r.delete();
      expq.delete();
   endtask

   // Every sample since reset is kept; wet is the sample D positions back once 512 are stored
   task automatic model_accept(input int sl, input int sr, input int depth, input int freq);
      int n, tv, d, wl, wr;
      exp_t e;
      n  = hist_l.size();
      tv = (ph >> 7) & 255;
      if (ph >= 32768) tv = 255 - tv;
      d  = BASE + (tv * depth) / 16;
      wl = 0;
      wr = 0;
      if (n >= 512) begin
         wl = hist_l[n-d];
         wr = hist_r[n-d];
      end
      hist_l.push_back(sl);
      hist_r.push_back(sr);
      ph = (ph + freq) % 65536;
      e.cyc = cyc + 3;
      e.l   = (sl >>> 1) + (wl >>> 1);
      e.r   = (sr >>> 1) + (wr >>> 1);
      expq.push_back(e);
   endtask

   // Called at a falling edge; returns 4 falling edges later with this sample's output held
   task automatic send(input int l, input int r, input int depth, input int freq, input int drop);
      logic [15:0] lv, rv;
      lv = l[15:0];
      rv = r[15:0];
      leftChan_i     = lv;
      rightChan_i    = rv;
      depthSetting_i = depth[3:0];
      freqSetting_i  = freq[3:0];
      sample_valid_i = 1'b1;
      model_accept(int'($signed(lv)), int'($signed(rv)), depth, freq);
      for (int k = 1; k <= 4; k++) begin
         @(negedge sclk_i);
         sample_valid_i = (k == drop);
         if (k == drop) begin
            leftChan_i  = 16'($urandom);
            rightChan_i = 16'($urandom);
         end
         depthSetting_i = 4'($urandom);
         freqSetting_i  = 4'($urandom);
      end
   endtask

   task automatic do_reset();
      rst_n_i        = 1'b0;
      sample_valid_i = 1'b0;
      model_reset();
      repeat (2) @(negedge sclk_i);
      rst_n_i = 1'b1;
      @(negedge sclk_i);
   endtask

   always @(negedge sclk_i) begin
      if (sample_valid_o === 1'b1) begin
         if (prev_vld) begin
            n_vec++;
            n_err++;
            $display("FAIL valid_back_to_back: got 2 consecutive cycles, expected 1 (cycle %0d)", cyc);
         end
         if (expq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid: got sample_valid_o=1, expected 0 (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = expq.pop_front();
            chk("valid_cycle", cyc, e.cyc);
            chk("left_out", int'($signed(leftChan_o)), e.l);
            chk("right_out", int'($signed(rightChan_o)), e.r);
         end
      end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
         exp_t e;
         e = expq.pop_front();
         n_vec++;
         n_err++;
         $display("FAIL missing_valid: got sample_valid_o=0, expected 1 at cycle %0d", e.cyc);
      end
      prev_vld = (sample_valid_o === 1'b1);
   end

   initial begin
      rst_n_i        = 1'b0;
      sample_valid_i = 1'b0;
      leftChan_i     = '0;
      rightChan_i    = '0;
      depthSetting_i = '0;
      freqSetting_i  = '0;
      repeat (2) @(negedge sclk_i);
      chk("reset_valid", int'(sample_valid_o), 0);
      chk("reset_left", int'($signed(leftChan_o)), 0);
      chk("reset_right", int'($signed(rightChan_o)), 0);
      rst_n_i = 1'b1;
      @(negedge sclk_i);

      // Priming: first 512 outputs are dry only
      for (int i = 0; i < 600; i++) begin
         send(1000, -1000, 0, 0, 0);
         if (i == 0 || i == 511) begin
            chk("unprimed_left", int'($signed(leftChan_o)), 500);
            chk("unprimed_right", int'($signed(rightChan_o)), -500);
         end
         if (i == 512 || i == 599) begin
            chk("primed_left", int'($signed(leftChan_o)), 1000);
            chk("primed_right", int'($signed(rightChan_o)), -1000);
         end
      end

      // Fixed delay impulse, with dropped strobes in RD/MIX on most samples
      do_reset();
      for (int i = 0; i <= 900; i++) begin
         send((i == 600) ? 16384 : 0, 0, 0, 0, i % 3);
         if (i == 600 || i == 856) chk("impulse_d0", int'($signed(leftChan_o)), 8192);
         if (i == 855 || i == 857) chk("impulse_d0_quiet", int'($signed(leftChan_o)), 0);
      end

      // Depth 15 with phase 0: tri is 0, echo still at 256
      do_reset();
      for (int i = 0; i <= 900; i++) begin
         send((i == 600) ? 16384 : 0, 0, 15, 0, 0);
         if (i == 856) chk("impulse_d15_ph0", int'($signed(leftChan_o)), 8192);
      end

      // Phase preloaded to 16384: tri 128, offset 120, echo at 376
      do_reset();
      for (int i = 0; i < 2048; i++) send(0, 0, 15, 8, 0);
      for (int j = 0; j <= 400; j++) begin
         send((j == 0) ? 16384 : 0, 0, 15, 0, 0);
         if (j == 256 || j == 375) chk("impulse_ph_quiet", int'($signed(leftChan_o)), 0);
         if (j == 376) chk("impulse_ph_echo", int'($signed(leftChan_o)), 8192);
      end

      // Full-scale extremes
      for (int i = 0; i < 520; i++) send(32767, 32767, 0, 0, 0);
      chk("max_left", int'($signed(leftChan_o)), 32766);
      for (int i = 0; i < 520; i++) send(-32768, -32768, 0, 0, 0);
      chk("min_left", int'($signed(leftChan_o)), -32768);

      // Dropped strobe yields exactly one output for the accepted pair
      send(1234, -1234, 0, 0, 1);
      chk("drop_rd_left", int'($signed(leftChan_o)), -15767);

      // Randomized settings, samples and drops
      do_reset();
      for (int i = 0; i < 1500; i++)
         send(int'($urandom), int'($urandom), int'($urandom_range(15)), int'($urandom_range(15)),
              int'($urandom_range(2)));
      repeat (4) @(negedge sclk_i);
      chk("queue_drained", expq.size(), 0);

      // Reset during RD discards the in-flight sample
      leftChan_i     = 16'd3000;
      rightChan_i    = 16'd3000;
      sample_valid_i = 1'b1;
      @(negedge sclk_i);
      sample_valid_i = 1'b0;
      rst_n_i        = 1'b0;
      model_reset();
      @(negedge sclk_i);
      rst_n_i = 1'b1;
      repeat (4) @(negedge sclk_i);
      chk("rst_rd_left", int'($signed(leftChan_o)), 0);
      chk("rst_rd_right", int'($signed(rightChan_o)), 0);
      send(1000, -1000, 0, 0, 0);
      chk("post_rst_left", int'($signed(leftChan_o)), 500);
      chk("post_rst_right", int'($signed(rightChan_o)), -500);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
